fifo_line_arbiter: RTL and testbench
====================================

# fifo_line_arbiter

Round-robin write arbiter that shares one synchronous pixel FIFO between two line-based pixel sources, e.g. two camera or filter streams feeding a common buffer. A grant is held for exactly one full line of LINE_LEN beats so lines from the two sources never interleave inside the FIFO. The arbiter drives the FIFO write port directly and back-pressures each source with a ready signal derived from grant ownership and FIFO full.

## Interface
- DATA_WIDTH, 16, pixel/beat width
- LINE_LEN, 640, beats per line (≥1); beat counter width = max(1, $clog2(LINE_LEN))

- sys_clk  in  1  single clock, all logic rising-edge
- sys_rst  in  1  synchronous, active-high reset
- req0_valid  in  1  source 0 has a beat
- req0_data  in  DATA_WIDTH  source 0 beat
- req0_ready  out  1  source 0 beat accepted this cycle when valid&ready
- req1_valid  in  1  source 1 has a beat
- req1_data  in  DATA_WIDTH  source 1 beat
- req1_ready  out  1  source 1 ready
- fifo_full  in  1  downstream FIFO full; no write while high
- fifo_wr_en  out  1  FIFO write strobe
- fifo_wr_data  out  DATA_WIDTH  FIFO write data
- busy  out  1  high while a line grant is held (state BURST)
- owner  out  1  index of current/last granted source
- line_done  out  1  one-cycle pulse after the last beat of a line

## Operation
- Reset (sys_rst=1 at edge): state=IDLE, beat_cnt=0, owner=0, rr_ptr=0, line_done=0. Combinational outputs then: busy=0, req0_ready=req1_ready=0, fifo_wr_en=0, fifo_wr_data=req0_data (mux follows owner).
- FSM states: IDLE, BURST.
- IDLE: selection on current req*_valid:
  - neither valid: stay IDLE.
  - exactly one valid: owner<=that index, go BURST.
  - both valid: owner<=rr_ptr, go BURST.
  - No beat accepted in IDLE (ready=0).
- BURST: reqN_ready = (owner==N) && !fifo_full; other source's ready=0.
  - Accepted beat = valid && ready of owner. fifo_wr_en = accepted beat (combinational, same cycle); fifo_wr_data = owner's data.
  - Accepted beat with beat_cnt<LINE_LEN-1: beat_cnt+1.
  - Accepted beat with beat_cnt==LINE_LEN-1: beat_cnt<=0, line_done<=1 next cycle, rr_ptr<=~owner, state<=IDLE.
  - Owner valid low or fifo_full high: hold, no write, count unchanged. No timeout; grant is held until line completes.
- owner is stable throughout BURST and retains last value in IDLE.
- line_done is registered, high exactly one cycle (the IDLE cycle following the last beat).
- Reset mid-line: partial line abandoned, all state as above; the FIFO is not flushed by this block.
- fifo_full never causes a dropped beat: writes only occur when !fifo_full.

## Timing
- Arbitration latency: a source asserting valid in IDLE at cycle t gets ready at t+1 (if !fifo_full).
- Throughput: LINE_LEN beats in LINE_LEN cycles when valid and !fifo_full continuous; one mandatory IDLE cycle between lines → LINE_LEN+1 cycles per line back-to-back.
- Write latency: zero; fifo_wr_en coincident with the source handshake.
- fifo_full sampled combinationally each cycle; deassertion allows a write the same cycle.
- Simultaneous valid on both at IDLE: rr_ptr decides; after a line from N, rr_ptr=~N, so contending sources strictly alternate.
- LINE_LEN=1: each accepted beat ends the line; BURST lasts until its single beat is accepted.

## Test plan
- Single source: LINE_LEN=4, req0_valid held high with data 0x10..0x13, fifo_full=0 → grant at cycle 1, fifo_wr_en high cycles 1-4 with 0x10..0x13, line_done at cycle 5, busy=0 at cycle 5, req1_ready never high.
- Contention: both valid continuously, LINE_LEN=4 → lines written in order src0, src1, src0, src1; each 4 contiguous beats, one idle cycle between; no interleaving.
- Back-pressure: fifo_full high for 3 cycles after 2nd beat → req0_ready and fifo_wr_en low for those 3 cycles, beat_cnt frozen at 2, remaining beats written after deassert, line still 4 beats.
- Source gaps: req1 sole owner toggles valid every other cycle → only valid cycles write; grant held; req0 asserting valid mid-line gets ready=0 until req1's line completes.
- Reset mid-line: sys_rst after 2 of 4 beats → next cycle busy=0, ready=0, fifo_wr_en=0, owner=0; new line starts with beat_cnt=0 and runs 4 full beats.
- LINE_LEN=1 with both valid → single-beat lines alternating 0,1,0,1 with line_done pulsing after each.

Source files
------------

// File: rtl/fifo_line_arbiter.sv
// fifo_line_arbiter: round-robin line arbiter sharing one pixel FIFO
// between two sources; a grant covers exactly LINE_LEN beats.
// Ports: sys_clk, sys_rst (sync, active-high);
//   req0/req1 valid/data in, ready out;
//   fifo_full in, fifo_wr_en/fifo_wr_data out;
//   busy (grant held), owner (current/last source),
//   line_done (1-cycle pulse after the last beat of a line).
module fifo_line_arbiter #(
  parameter int DATA_WIDTH = 16,
  parameter int LINE_LEN   = 640
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst,
  input  logic                  req0_valid,
  input  logic [DATA_WIDTH-1:0] req0_data,
  output logic                  req0_ready,
  input  logic                  req1_valid,
  input  logic [DATA_WIDTH-1:0] req1_data,
  output logic                  req1_ready,
  input  logic                  fifo_full,
  output logic                  fifo_wr_en,
  output logic [DATA_WIDTH-1:0] fifo_wr_data,
  output logic                  busy,
  output logic                  owner,
  output logic                  line_done
);

  localparam int CW = (LINE_LEN > 1) ? $clog2(LINE_LEN) : 1;
  localparam logic [CW-1:0] LAST = CW'(LINE_LEN - 1);

  typedef enum logic {
    IDLE,
    BURST
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          owner_q, owner_d;
  logic          rr_q, rr_d;
  logic          done_q, done_d;
  logic          own_valid;
  logic          beat;

  always_comb begin
    own_valid  = owner_q ? req1_valid : req0_valid;
    busy       = (state_q == BURST);
    req0_ready = busy && !owner_q && !fifo_full;
    req1_ready = busy && owner_q && !fifo_full;
    beat       = busy && own_valid && !fifo_full;
  end

  assign fifo_wr_en   = beat;
  assign fifo_wr_data = owner_q ? req1_data : req0_data;
  assign owner        = owner_q;
  assign line_done    = done_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    owner_d = owner_q;
    rr_d    = rr_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req0_valid || req1_valid) begin
          state_d = BURST;
          unique case (1'b1)
            req0_valid && req1_valid:  owner_d = rr_q;
            req1_valid && !req0_valid: owner_d = 1'b1;
            default:                   owner_d = 1'b0;
          endcase
        end
      end
      BURST: begin
        if (beat) begin
          if (cnt_q == LAST) begin
            cnt_d   = '0;
            done_d  = 1'b1;
            rr_d    = ~owner_q;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      owner_q <= 1'b0;
      rr_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_fifo_line_arbiter.sv
// tb_fifo_line_arbiter: random and directed checks of two arbiter
// instances (LINE_LEN=4 and LINE_LEN=1) against a line-level model.
module tb_fifo_line_arbiter;

  localparam int DW = 16;

  logic          sys_clk = 1'b0;
  logic          rst = 1'b1;
  logic          v0 = 1'b0, v1 = 1'b0, full = 1'b0;
  logic [DW-1:0] d0 = '0, d1 = '0;

  logic          r0_o[2], r1_o[2], wr_o[2];
  logic          busy_o[2], own_o[2], done_o[2];
  logic [DW-1:0] wd_o[2];

  int vectors = 0;
  int miscompares = 0;

  bit m_busy[2], m_own[2], m_rr[2], m_done[2];
  int m_beats[2];
  int m_len[2] = '{4, 1};

  always #5 sys_clk = ~sys_clk;

  fifo_line_arbiter #(.DATA_WIDTH(DW), .LINE_LEN(4)) dut4 (
    .sys_clk(sys_clk), .sys_rst(rst),
    .req0_valid(v0), .req0_data(d0), .req0_ready(r0_o[0]),
    .req1_valid(v1), .req1_data(d1), .req1_ready(r1_o[0]),
    .fifo_full(full), .fifo_wr_en(wr_o[0]), .fifo_wr_data(wd_o[0]),
    .busy(busy_o[0]), .owner(own_o[0]), .line_done(done_o[0])
  );

  fifo_line_arbiter #(.DATA_WIDTH(DW), .LINE_LEN(1)) dut1 (
    .sys_clk(sys_clk), .sys_rst(rst),
    .req0_valid(v0), .req0_data(d0), .req0_ready(r0_o[1]),
    .req1_valid(v1), .req1_data(d1), .req1_ready(r1_o[1]),
    .fifo_full(full), .fifo_wr_en(wr_o[1]), .fifo_wr_data(wd_o[1]),
    .busy(busy_o[1]), .owner(own_o[1]), .line_done(done_o[1])
  );

  // Line-level model: a grant lasts until m_len beats have been written.
  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m_busy[k] = 0; m_own[k] = 0; m_rr[k] = 0;
        m_done[k] = 0; m_beats[k] = 0;
      end else begin
        m_done[k] = 0;
        if (!m_busy[k]) begin
          if (v0 || v1) begin
            m_busy[k] = 1;
            if (v0 && v1) m_own[k] = m_rr[k];
            else m_own[k] = v1;
          end
        end else if ((m_own[k] ? v1 : v0) && !full) begin
          m_beats[k] = m_beats[k] + 1;
          if (m_beats[k] == m_len[k]) begin
            m_beats[k] = 0;
            m_done[k] = 1;
            m_rr[k] = !m_own[k];
            m_busy[k] = 0;
          end
        end
      end
    end
  endtask

  function automatic logic [21:0] exp_vec(input int k);
    logic ov;
    ov = m_own[k] ? v1 : v0;
    return {m_busy[k], m_own[k], m_done[k],
            m_busy[k] && !m_own[k] && !full,
            m_busy[k] && m_own[k] && !full,
            m_busy[k] && ov && !full,
            m_own[k] ? d1 : d0};
  endfunction

  function automatic logic [21:0] obs_vec(input int k);
    return {busy_o[k], own_o[k], done_o[k],
            r0_o[k], r1_o[k], wr_o[k], wd_o[k]};
  endfunction

  task automatic tick();
    @(posedge sys_clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    rst = 1; v0 = 0; v1 = 0; full = 0;
    tick();
    rst = 0;
  endtask

  task automatic test_reset();
    rst = 1; v0 = 1; v1 = 1; full = 0;
    d0 = 16'h1234; d1 = 16'h5678;
    tick();
    rst = 0;
    @(negedge sys_clk);
    for (int k = 0; k < 2; k++) begin
      vectors++;
      if ({busy_o[k], own_o[k], done_o[k], r0_o[k], r1_o[k], wr_o[k]}
          !== 6'b0 || wd_o[k] !== 16'h1234) begin
        miscompares++;
        $display("FAIL reset k=%0d got %b/%h want 000000/1234", k,
                 {busy_o[k], own_o[k], done_o[k], r0_o[k], r1_o[k],
                  wr_o[k]}, wd_o[k]);
      end
    end
    do_reset();
  endtask

  task automatic test_single();
    int n = 0;
    do_reset();
    v0 = 1; v1 = 0;
    for (int c = 0; c < 7; c++) begin
      d0 = 16'h10 + 16'(n);
      @(negedge sys_clk);
      for (int k = 0; k < 2; k++) begin
        vectors++;
        if (obs_vec(k) !== exp_vec(k)) begin
          miscompares++;
          $display("FAIL single c=%0d k=%0d got %h want %h",
                   c, k, obs_vec(k), exp_vec(k));
        end
      end
      vectors++;
      if (r1_o[0] !== 1'b0) begin
        miscompares++;
        $display("FAIL single_r1 c=%0d got %b want 0", c, r1_o[0]);
      end
      if (wr_o[0]) n++;
      tick();
    end
  endtask

  task automatic test_contention();
    do_reset();
    v0 = 1; v1 = 1;
    for (int c = 0; c < 24; c++) begin
      d0 = 16'($urandom); d1 = 16'($urandom);
      @(negedge sys_clk);
      for (int k = 0; k < 2; k++) begin
        vectors++;
        if (obs_vec(k) !== exp_vec(k)) begin
          miscompares++;
          $display("FAIL contention c=%0d k=%0d got %h want %h",
                   c, k, obs_vec(k), exp_vec(k));
        end
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    int n = 0;
    int fc = 0;
    do_reset();
    v1 = 0;
    for (int c = 0; c < 12; c++) begin
      v0 = (n < 4);
      full = (n == 2 && fc < 3);
      if (full) fc++;
      d0 = 16'h20 + 16'(n);
      @(negedge sys_clk);
      for (int k = 0; k < 2; k++) begin
        vectors++;
        if (obs_vec(k) !== exp_vec(k)) begin
          miscompares++;
          $display("FAIL backpressure c=%0d k=%0d got %h want %h",
                   c, k, obs_vec(k), exp_vec(k));
        end
      end
      if (wr_o[0]) n++;
      tick();
    end
    full = 0;
    vectors++;
    if (n !== 4) begin
      miscompares++;
      $display("FAIL backpressure_beats got %0d want 4", n);
    end
  endtask

  task automatic test_gaps();
    do_reset();
    for (int c = 0; c < 16; c++) begin
      v1 = (c % 2 == 0);
      v0 = (c >= 3);
      d0 = 16'($urandom); d1 = 16'($urandom);
      @(negedge sys_clk);
      for (int k = 0; k < 2; k++) begin
        vectors++;
        if (obs_vec(k) !== exp_vec(k)) begin
          miscompares++;
          $display("FAIL gaps c=%0d k=%0d got %h want %h",
                   c, k, obs_vec(k), exp_vec(k));
        end
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    bit done_rst = 0;
    do_reset();
    v0 = 1; v1 = 0;
    for (int c = 0; c < 12; c++) begin
      rst = (n == 2 && !done_rst);
      if (rst) done_rst = 1;
      d0 = 16'h30 + 16'(c);
      @(negedge sys_clk);
      for (int k = 0; k < 2; k++) begin
        vectors++;
        if (obs_vec(k) !== exp_vec(k)) begin
          miscompares++;
          $display("FAIL reset_mid c=%0d k=%0d got %h want %h",
                   c, k, obs_vec(k), exp_vec(k));
        end
      end
      if (wr_o[0]) n++;
      tick();
    end
    rst = 0;
  endtask

  task automatic test_line_len1();
    bit want = 0;
    do_reset();
    v0 = 1; v1 = 1; full = 0;
    for (int c = 0; c < 12; c++) begin
      d0 = 16'($urandom); d1 = 16'($urandom);
      @(negedge sys_clk);
      for (int k = 0; k < 2; k++) begin
        vectors++;
        if (obs_vec(k) !== exp_vec(k)) begin
          miscompares++;
          $display("FAIL len1 c=%0d k=%0d got %h want %h",
                   c, k, obs_vec(k), exp_vec(k));
        end
      end
      if (wr_o[1]) begin
        vectors++;
        if (own_o[1] !== want) begin
          miscompares++;
          $display("FAIL len1_alt c=%0d got %b want %b",
                   c, own_o[1], want);
        end
        want = !want;
      end
      tick();
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      rst  = ($urandom_range(0, 99) < 2);
      v0   = ($urandom_range(0, 3) != 0);
      v1   = ($urandom_range(0, 2) != 0);
      full = ($urandom_range(0, 3) == 0);
      d0 = 16'($urandom); d1 = 16'($urandom);
      @(negedge sys_clk);
      for (int k = 0; k < 2; k++) begin
        vectors++;
        if (obs_vec(k) !== exp_vec(k)) begin
          miscompares++;
          $display("FAIL random c=%0d k=%0d got %h want %h",
                   c, k, obs_vec(k), exp_vec(k));
        end
      end
      tick();
    end
    rst = 0; full = 0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_gaps();
    test_reset_mid();
    test_line_len1();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
